// File: rtl/pulse_sequencer.sv
// -----------------------------------------------------------------------------
// pulse_sequencer
//
// Pulse register and scheduler that sits behind the quantum instruction
// handler. Pulse descriptors {pulse memory address, pre-delay} are buffered in
// a small FIFO and issued strictly in order to the pulse playback engine:
// wait the descriptor's pre-delay, strobe pulse_start for one cycle, then wait
// for pulse_done before taking the next descriptor.
//
// Parameters
//   DEPTH    descriptor FIFO entries (power of two, >= 2)
//   ADDR_W   pulse memory address width
//   DELAY_W  pre-pulse delay width, in clk cycles
//
// Ports
//   clk                     in   system clock, rising edge
//   reset                   in   asynchronous active-high reset
//   pulse_descriptor        in   {pulse_mem_addr, delay}
//   pulse_descriptor_valid  in   push request, one entry per cycle while high
//   pulse_register_full     out  FIFO holds DEPTH entries
//   pulse_register_empty    out  FIFO empty and no pulse pending or playing
//   fifo_count              out  entries currently stored
//   pulse_start             out  one-cycle start strobe to the playback engine
//   pulse_addr              out  address of the issued pulse, held until the
//                                next issue
//   pulse_done              in   playback engine finished the current pulse
//   pulse_overflow          out  sticky: a push was attempted while full
// -----------------------------------------------------------------------------
module pulse_sequencer #(
   parameter int DEPTH   = 8,
   parameter int ADDR_W  = 32,
   parameter int DELAY_W = 12
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [ADDR_W+DELAY_W-1:0] pulse_descriptor,
   input  logic                      pulse_descriptor_valid,
   output logic                      pulse_register_full,
   output logic                      pulse_register_empty,
   output logic [$clog2(DEPTH):0]    fifo_count,
   output logic                      pulse_start,
   output logic [ADDR_W-1:0]         pulse_addr,
   input  logic                      pulse_done,
   output logic                      pulse_overflow
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int DESC_W = ADDR_W + DELAY_W;
   localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DELAY = 2'd1,
      ISSUE = 2'd2,
      PLAY  = 2'd3
   } state_t;

   // Pointer advance; DEPTH is a power of two so the natural wrap of a
   // PTR_W-bit counter gives modulo-DEPTH addressing.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return p + PTR_W'(1);
   endfunction

   function automatic logic [DELAY_W-1:0] delay_dec(input logic [DELAY_W-1:0] d);
      return d - DELAY_W'(1);
   endfunction

   state_t               state, state_nxt;
   logic [DESC_W-1:0]    mem [DEPTH];
   logic [PTR_W-1:0]     wr_ptr, rd_ptr;
   logic [PTR_W:0]       count;
   logic [DELAY_W-1:0]   delay_cnt, delay_cnt_nxt;
   logic [ADDR_W-1:0]    addr_q, addr_nxt;
   logic [ADDR_W-1:0]    pulse_addr_nxt;
   logic [DESC_W-1:0]    head;
   logic [ADDR_W-1:0]    head_addr;
   logic [DELAY_W-1:0]   head_delay;
   logic                 fifo_empty;
   logic                 push;
   logic                 pop;

   // Status is derived from registered state only. A push while full is
   // refused even if the FSM pops in the same cycle.
   assign fifo_empty           = (count == '0);
   assign pulse_register_full  = (count == FULL_COUNT);
   assign pulse_register_empty = fifo_empty && (state == IDLE);
   assign fifo_count           = count;
   assign push                 = pulse_descriptor_valid && !pulse_register_full;

   assign head       = mem[rd_ptr];
   assign head_addr  = head[DESC_W-1:DELAY_W];
   assign head_delay = head[DELAY_W-1:0];

   // Descriptor storage: payload only, never needs a reset value.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= pulse_descriptor;
      end
   end

   // FIFO control and sticky overflow flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         pulse_overflow <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         case ({push, pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
         if (pulse_descriptor_valid && pulse_register_full) begin
            pulse_overflow <= 1'b1;
         end
      end
   end

   // Scheduler state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         delay_cnt  <= '0;
         addr_q     <= '0;
         pulse_addr <= '0;
      end else begin
         state      <= state_nxt;
         delay_cnt  <= delay_cnt_nxt;
         addr_q     <= addr_nxt;
         pulse_addr <= pulse_addr_nxt;
      end
   end

   // Scheduler next-state and outputs. pulse_addr is loaded on the transition
   // into ISSUE so it changes only when a new pulse is issued.
   always_comb begin
      state_nxt      = state;
      delay_cnt_nxt  = delay_cnt;
      addr_nxt       = addr_q;
      pulse_addr_nxt = pulse_addr;
      pop            = 1'b0;
      pulse_start    = 1'b0;

      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop           = 1'b1;
               addr_nxt      = head_addr;
               delay_cnt_nxt = head_delay;
               if (head_delay == '0) begin
                  state_nxt      = ISSUE;
                  pulse_addr_nxt = head_addr;
               end else begin
                  state_nxt = DELAY;
               end
            end
         end

         // The counter is loaded with D on entry and leaves at 1, so exactly
         // D cycles are spent here.
         DELAY: begin
            if (delay_cnt == DELAY_W'(1)) begin
               state_nxt      = ISSUE;
               pulse_addr_nxt = addr_q;
            end else begin
               delay_cnt_nxt = delay_dec(delay_cnt);
            end
         end

         ISSUE: begin
            pulse_start = 1'b1;
            state_nxt   = PLAY;
         end

         PLAY: begin
            if (pulse_done) begin
               state_nxt = IDLE;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule
